// File: rtl/imm_ext_unit.sv
// Immediate-generation stage: extracts and extends an instruction's immediate field,
// merges EXTEND prefix payloads, and presents the result through a one-deep valid/ready register.
module imm_ext_unit #(
  parameter int         INST_W    = 16,
  parameter int         DATA_W    = 16,
  parameter logic [4:0] PREFIX_OP = 5'b11110
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] inst,
  input  logic [2:0]        mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] imm,
  output logic              prefixed,
  output logic              err
);

  typedef enum logic {IDLE, HELD} state_t;

  state_t            state_q;
  logic [10:0]       prefix_q;
  logic              out_valid_q;
  logic              prefixed_q;
  logic              err_q;
  logic [DATA_W-1:0] imm_q;

  logic              accept;
  logic              is_prefix;
  logic              mode_bad;
  logic [DATA_W-1:0] field_imm;
  logic [DATA_W-1:0] pair_imm;
  logic [15:0]       pair_word;

  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign is_prefix = (inst[15:11] == PREFIX_OP);

  // The prefix payload forms the upper 11 bits; the full 16-bit word is then sign-extended.
  assign pair_word = {prefix_q, inst[4:0]};
  assign pair_imm  = DATA_W'($signed(pair_word));

  always_comb begin
    field_imm = '0;
    mode_bad  = 1'b0;
    case (mode)
      3'd0:    field_imm = DATA_W'($signed(inst[3:0]));
      3'd1:    field_imm = DATA_W'($signed(inst[4:0]));
      3'd2:    field_imm = DATA_W'($signed(inst[7:0]));
      3'd3:    field_imm = DATA_W'(inst[7:0]);
      3'd4:    field_imm = DATA_W'($signed(inst[10:0]));
      3'd5:    field_imm = DATA_W'(inst[4:2]);
      default: mode_bad  = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      prefix_q    <= '0;
      out_valid_q <= 1'b0;
      imm_q       <= '0;
      prefixed_q  <= 1'b0;
      err_q       <= 1'b0;
    end else if (flush) begin
      state_q     <= IDLE;
      prefix_q    <= '0;
      out_valid_q <= 1'b0;
      prefixed_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      // A new result overrides the consume above, giving one transfer per cycle.
      if (accept) begin
        if (is_prefix) begin
          prefix_q <= inst[10:0];
          state_q  <= HELD;
          err_q    <= (state_q == HELD);
        end else if (state_q == HELD) begin
          imm_q       <= pair_imm;
          prefixed_q  <= 1'b1;
          out_valid_q <= 1'b1;
          prefix_q    <= '0;
          state_q     <= IDLE;
        end else begin
          imm_q       <= field_imm;
          prefixed_q  <= 1'b0;
          out_valid_q <= 1'b1;
          err_q       <= mode_bad;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign imm       = imm_q;
  assign prefixed  = prefixed_q;
  assign err       = err_q;

endmodule

// File: tb/tb_imm_ext_unit.sv
// Scoreboard bench for imm_ext_unit: a reference model predicts each output at the accepting
// edge, and an independent monitor compares whatever the DUT presents on the opposite edge.
module tb_imm_ext_unit;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   inst;
  logic [2:0]    mode;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] imm;
  logic          prefixed;
  logic          err;

  imm_ext_unit #(.INST_W(16), .DATA_W(DW), .PREFIX_OP(5'b11110)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .inst(inst), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .imm(imm), .prefixed(prefixed), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] imm;
    logic          pre;
  } exp_t;

  exp_t        sbq[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  bit          mon_en   = 1'b0;
  bit          mdl_en   = 1'b0;
  bit          held     = 1'b0;
  logic [10:0] pfx      = '0;
  logic        exp_err  = 1'b0;
  logic [15:0] ri;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  // Reference: pick the field by mode, then sign/zero-extend with plain integer arithmetic.
  function automatic logic [DW-1:0] ref_field(input logic [15:0] i, input logic [2:0] m);
    int lo, w;
    bit sgn;
    longint f;
    logic [63:0] t;
    case (m)
      3'd0: begin lo = 0; w = 4;  sgn = 1; end
      3'd1: begin lo = 0; w = 5;  sgn = 1; end
      3'd2: begin lo = 0; w = 8;  sgn = 1; end
      3'd3: begin lo = 0; w = 8;  sgn = 0; end
      3'd4: begin lo = 0; w = 11; sgn = 1; end
      3'd5: begin lo = 2; w = 3;  sgn = 0; end
      default: return '0;
    endcase
    f = longint'((i >> lo) & ((16'd1 << w) - 16'd1));
    if (sgn && f >= (longint'(1) << (w - 1))) f = f - (longint'(1) << w);
    t = 64'(f);
    return t[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] ref_pair(input logic [10:0] p, input logic [15:0] i);
    longint f;
    logic [63:0] t;
    f = longint'(p) * 32 + longint'(i & 16'h1F);
    if (f >= 32768) f = f - 65536;
    t = 64'(f);
    return t[DW-1:0];
  endfunction

  // Model: observes the inputs at each active edge and predicts outputs/err.
  always @(posedge clk) begin
    if (mdl_en && !rst) begin
      bit rdy;
      rdy = (sbq.size() == 0) || out_ready;
      exp_err = 1'b0;
      if (flush) begin
        sbq.delete();
        held = 1'b0;
        pfx  = '0;
      end else if (in_valid && rdy) begin
        if (inst[15:11] == 5'b11110) begin
          if (held) exp_err = 1'b1;
          held = 1'b1;
          pfx  = inst[10:0];
        end else if (held) begin
          sbq.push_back('{imm: ref_pair(pfx, inst), pre: 1'b1});
          held = 1'b0;
        end else begin
          sbq.push_back('{imm: ref_field(inst, mode), pre: 1'b0});
          exp_err = (mode >= 3'd6);
        end
      end
    end
  end

  // Monitor: compares the presented output against the scoreboard head.
  always @(negedge clk) begin
    if (mon_en) begin
      check("out_valid", 64'(out_valid), 64'(sbq.size() != 0));
      check("in_ready", 64'(in_ready), 64'((sbq.size() == 0) || out_ready));
      check("err", 64'(err), 64'(exp_err));
      if (sbq.size() != 0) begin
        check("imm", 64'(imm), 64'(sbq[0].imm));
        check("prefixed", 64'(prefixed), 64'(sbq[0].pre));
        if (out_ready) begin
          $display("out imm=%h prefixed=%0d", imm, prefixed);
          void'(sbq.pop_front());
        end
      end
    end
  end

  task automatic drv(input bit v, input logic [15:0] i, input logic [2:0] m,
                     input bit ordy, input bit fl);
    in_valid  = v;
    inst      = i;
    mode      = m;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; inst = '0; mode = '0; out_ready = 1'b0;
    #12 rst = 1'b0;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_imm", 64'(imm), 64'd0);
    check("rst_prefixed", 64'(prefixed), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    @(posedge clk); #1;
    mdl_en = 1'b1;
    mon_en = 1'b1;

    drv(1, 16'h470F, 3'd0, 1, 0);
    drv(1, 16'h4707, 3'd0, 1, 0);
    drv(1, 16'h0080, 3'd2, 1, 0);
    drv(1, 16'h0080, 3'd3, 1, 0);
    drv(1, 16'h0400, 3'd4, 1, 0);
    drv(1, 16'h001C, 3'd5, 1, 0);
    drv(1, 16'hF7FF, 3'd0, 1, 0);
    drv(1, 16'h4815, 3'd3, 1, 0);
    drv(1, 16'hF001, 3'd0, 1, 0);
    drv(1, 16'hF002, 3'd0, 1, 0);
    drv(1, 16'h4801, 3'd0, 1, 0);

    drv(1, 16'h0005, 3'd1, 0, 0);
    for (int k = 0; k < 5; k++) drv(1, 16'h0006, 3'd1, 0, 0);
    drv(1, 16'h0006, 3'd1, 1, 0);
    drv(1, 16'h0007, 3'd1, 1, 0);
    drv(0, 16'h0000, 3'd0, 1, 0);

    drv(1, 16'hF7FF, 3'd0, 1, 0);
    drv(1, 16'h1111, 3'd0, 1, 1);
    drv(1, 16'h4815, 3'd1, 1, 0);
    drv(1, 16'h1234, 3'd6, 1, 0);
    drv(1, 16'h1234, 3'd7, 1, 0);
    drv(0, 16'h0000, 3'd0, 1, 0);

    // Asynchronous reset while an output is pending.
    drv(1, 16'h00F3, 3'd2, 0, 0);
    mon_en = 1'b0;
    mdl_en = 1'b0;
    in_valid = 1'b0;
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_imm", 64'(imm), 64'd0);
    #3 rst = 1'b0;
    sbq.delete();
    held = 1'b0;
    pfx = '0;
    exp_err = 1'b0;
    @(posedge clk); #1;
    mdl_en = 1'b1;
    mon_en = 1'b1;

    for (int k = 0; k < 400; k++) begin
      ri = 16'($urandom);
      if ($urandom_range(0, 4) == 0) ri[15:11] = 5'b11110;
      drv($urandom_range(0, 9) < 7, ri, 3'($urandom_range(0, 7)),
          $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
    end

    for (int k = 0; k < 3; k++) drv(0, 16'h0000, 3'd0, 1, 0);
    check("drained", 64'(sbq.size()), 64'd0);
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/imm_ext_unit.md
Name: imm_ext_unit

Overview:
- Registered immediate-generation stage for the ID path of the 16-bit CPU.
- Extracts the immediate field of a fetched instruction, sign- or zero-extends it to DATA_W according to a field-select mode, and presents it to execute through a valid/ready pipeline register.
- Also implements the EXTEND prefix: a prefix instruction's 11-bit payload is held and concatenated with the 5-bit field of the next instruction to form a full 16-bit immediate.

Parameters:
- INST_W, 16, instruction width; fixed at 16.
- DATA_W, 16, immediate output width; must be >= 16.
- PREFIX_OP, 5'b11110, value of inst[15:11] that identifies an EXTEND prefix.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous pipeline flush.
- in_valid  input  1  inst/mode valid.
- in_ready  output  1  stage can accept input.
- inst  input  INST_W  instruction word.
- mode  input  3  field select (see Behaviour).
- out_valid  output  1  imm valid.
- out_ready  input  1  downstream accepts.
- imm  output  DATA_W  extended immediate.
- prefixed  output  1  imm was built from an EXTEND pair.
- err  output  1  one-cycle pulse: illegal mode or back-to-back prefix.

Behaviour:
- Reset (async, rst=1): state=IDLE, prefix register=0, out_valid=0, imm=0, prefixed=0, err=0.
- Handshake:
  - in_ready = !out_valid | out_ready.
  - A transfer occurs when in_valid & in_ready.
  - Output is consumed when out_valid & out_ready.
  - Latency is 1 cycle: imm appears the cycle after the accepting edge.
  - While out_valid=1 and out_ready=0, imm and prefixed are held stable.
- Mode encoding. Field is taken exactly from the bits listed; sign bit is the field MSB:
  - 0 SE4: inst[3:0]
  - 1 SE5: inst[4:0]
  - 2 SE8: inst[7:0]
  - 3 ZE8: inst[7:0]
  - 4 SE11: inst[10:0]
  - 5 ZE3: inst[4:2]
  - 6, 7 reserved: imm=0, err=1 for that output cycle; the output is still produced.
- FSM states: IDLE, HELD.
- IDLE transitions, on an accepted inst:
  - If inst[15:11]==PREFIX_OP: capture inst[10:0] into the prefix register, go to HELD. No output produced (out_valid drops if it was consumed), err=0.
  - Otherwise: out_valid=1, imm=extend(mode field), prefixed=0.
- HELD transitions, on an accepted inst:
  - Non-prefix inst: imm = sign-extend of {prefix[10:0], inst[4:0]} to DATA_W; mode is ignored. prefixed=1, out_valid=1, go to IDLE.
  - Another prefix inst: the prefix register is overwritten with the new payload, state stays HELD, err pulses 1 cycle, no output.
- HELD with no accepted input: the prefix is held indefinitely.
- Flush (sync, priority over any same-cycle transfer):
  - Next state IDLE, prefix register cleared, out_valid=0, prefixed=0, err=0.
  - The instruction presented in the flush cycle is discarded.
- err is registered: asserted in the cycle after the offending accept, cleared the following cycle unless re-triggered.
- Simultaneous consume and accept: the new output replaces the old in the same edge, giving back-to-back throughput of one per cycle.
- Reset mid-operation (out_valid=1 or HELD) returns all outputs and state to reset values immediately.

Test Plan:
- Reset then mode=0, inst=0x470F -> next cycle out_valid=1, imm=0xFFFF, prefixed=0. Then mode=0, inst=0x4707 -> imm=0x0007.
- inst=0x0080 with mode=2 -> imm=0xFF80; same inst with mode=3 -> imm=0x0080. With mode=4, inst=0x0400 -> imm=0xFC00. With mode=5, inst=0x001C -> imm=0x0007.
- Prefix pair: inst=0xF7FF, then inst=0x4815 (mode=3) -> the first accept gives no output; the second gives imm=0xFFF5, prefixed=1. With DATA_W=32 -> imm=0xFFFFFFF5.
- Back-to-back prefix: 0xF001 then 0xF002 then 0x4801 -> err pulses once after the 2nd prefix; imm=0x0041 (payload 0x002), prefixed=1.
- Backpressure: hold out_ready=0 after an output -> in_ready=0, imm stable for 5 cycles. Release -> the next queued inst completes with one transfer per cycle, no loss or duplication.
- Flush in HELD (after 0xF7FF), then inst=0x4815 mode=1 -> imm=0xFFF5 via SE5, prefixed=0. Async rst while out_valid=1 -> out_valid=0, imm=0 without waiting for a clock edge. Mode=6 -> imm=0, err=1 for one cycle.
